// File: rtl/id_decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_stage_if
// Purpose  : Fetch->decode->execute handshake bundle for id_decode_stage.
//            slave  : decode-stage view (consumes fetch, produces bundle)
//            master : surrounding view (drives fetch side, consumes bundle)
// Signals  : flush, in_valid/in_ready/in_instr/in_pc,
//            out_valid/out_ready, out_pc, out_rs1/rs2/rd, out_imm,
//            control flags, load/store types, alu_ctrl, is_muldiv, illegal
// Revision : 1.0 - initial release
// ============================================================================
interface id_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_alu_src;
    logic            out_mem_write;
    logic            out_mem_read;
    logic            out_wb_reg_file;
    logic            out_memtoreg;
    logic            out_branch;
    logic            out_jal;
    logic            out_jalr;
    logic            out_auipc;
    logic            out_lui;
    logic [2:0]      out_mem_load_type;
    logic [1:0]      out_mem_store_type;
    logic [4:0]      out_alu_ctrl;
    logic            out_is_muldiv;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_src, out_mem_write, out_mem_read, out_wb_reg_file,
               out_memtoreg, out_branch, out_jal, out_jalr, out_auipc, out_lui,
               out_mem_load_type, out_mem_store_type, out_alu_ctrl,
               out_is_muldiv, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_src, out_mem_write, out_mem_read, out_wb_reg_file,
               out_memtoreg, out_branch, out_jal, out_jalr, out_auipc, out_lui,
               out_mem_load_type, out_mem_store_type, out_alu_ctrl,
               out_is_muldiv, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_stage
// Purpose  : Registered RV32I(+M) decode stage with a two-entry skid buffer.
//            Instructions are decoded before being written into the main (M)
//            or skid (S) register; outputs come only from M, and in_ready is
//            a flop, so no combinational path exists from execute to fetch.
// Ports    : clk  - clock, all state on rising edge
//            rst  - synchronous active-high reset (priority over flush)
//            bus  - id_decode_stage_if.slave (flush, fetch side, execute side)
// Params   : XLEN (imm width), PC_W (pc width), EN_M (1 = decode RV32M)
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32,
    parameter bit EN_M = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    id_decode_stage_if.slave  bus
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic            mem_write;
        logic            mem_read;
        logic            wb_reg_file;
        logic            memtoreg;
        logic            branch;
        logic            jal;
        logic            jalr;
        logic            auipc;
        logic            lui;
        logic [2:0]      load_type;
        logic [1:0]      store_type;
        logic [4:0]      alu_ctrl;
        logic            is_muldiv;
        logic            illegal;
    } bundle_t;

    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_one   = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [4:0] c_alu_add   = 5'b00000;
    localparam logic [4:0] c_alu_sub   = 5'b00001;
    localparam logic [4:0] c_alu_and   = 5'b00010;
    localparam logic [4:0] c_alu_or    = 5'b00011;
    localparam logic [4:0] c_alu_xor   = 5'b00100;
    localparam logic [4:0] c_alu_sll   = 5'b00101;
    localparam logic [4:0] c_alu_srl   = 5'b00110;
    localparam logic [4:0] c_alu_sra   = 5'b00111;
    localparam logic [4:0] c_alu_slt   = 5'b01000;
    localparam logic [4:0] c_alu_sltu  = 5'b01001;
    localparam logic [4:0] c_alu_lui   = 5'b01010;
    localparam logic [4:0] c_alu_auipc = 5'b01011;

    localparam logic [6:0] c_f7_zero = 7'b0000000;
    localparam logic [6:0] c_f7_alt  = 7'b0100000;
    localparam logic [6:0] c_f7_mul  = 7'b0000001;

    logic [1:0]  r_state;
    logic        r_m_valid;
    logic        r_in_ready;
    bundle_t     r_m;
    bundle_t     r_s;
    bundle_t     w_dec;
    bundle_t     w_reset_bundle;
    logic        w_in_fire;
    logic        w_out_fire;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_instr  = bus.in_instr;
    assign w_opcode = w_instr[6:0];
    assign w_f3     = w_instr[14:12];
    assign w_f7     = w_instr[31:25];

    assign w_imm_i = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    // Value held in M/S after reset: everything zero except the load/store
    // size fields, which idle at word size.
    always_comb begin
        w_reset_bundle            = '0;
        w_reset_bundle.load_type  = 3'b010;
        w_reset_bundle.store_type = 2'b10;
    end

    always_comb begin
        w_dec      = w_reset_bundle;
        w_dec.pc   = bus.in_pc;
        w_dec.rs1  = w_instr[19:15];
        w_dec.rs2  = w_instr[24:20];
        w_dec.rd   = w_instr[11:7];
        case (w_opcode)
            c_op_r: begin
                w_dec.wb_reg_file = 1'b1;
                if (w_f7 == c_f7_zero) begin
                    case (w_f3)
                        3'b000:  w_dec.alu_ctrl = c_alu_add;
                        3'b001:  w_dec.alu_ctrl = c_alu_sll;
                        3'b010:  w_dec.alu_ctrl = c_alu_slt;
                        3'b011:  w_dec.alu_ctrl = c_alu_sltu;
                        3'b100:  w_dec.alu_ctrl = c_alu_xor;
                        3'b101:  w_dec.alu_ctrl = c_alu_srl;
                        3'b110:  w_dec.alu_ctrl = c_alu_or;
                        default: w_dec.alu_ctrl = c_alu_and;
                    endcase
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b000) begin
                    w_dec.alu_ctrl = c_alu_sub;
                end else if (w_f7 == c_f7_alt && w_f3 == 3'b101) begin
                    w_dec.alu_ctrl = c_alu_sra;
                end else if (w_f7 == c_f7_mul && EN_M) begin
                    // M-ops map func3 straight onto the low bits: MUL=10000 .. REMU=10111
                    w_dec.alu_ctrl  = {2'b10, w_f3};
                    w_dec.is_muldiv = 1'b1;
                end else begin
                    w_dec.illegal = 1'b1;
                end
            end
            c_op_imm: begin
                w_dec.alu_src     = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.imm         = w_imm_i;
                case (w_f3)
                    3'b000: w_dec.alu_ctrl = c_alu_add;
                    3'b010: w_dec.alu_ctrl = c_alu_slt;
                    3'b011: w_dec.alu_ctrl = c_alu_sltu;
                    3'b100: w_dec.alu_ctrl = c_alu_xor;
                    3'b110: w_dec.alu_ctrl = c_alu_or;
                    3'b111: w_dec.alu_ctrl = c_alu_and;
                    3'b001: begin
                        w_dec.alu_ctrl = c_alu_sll;
                        w_dec.illegal  = (w_f7 != c_f7_zero);
                    end
                    default: begin
                        if (w_f7 == c_f7_zero) begin
                            w_dec.alu_ctrl = c_alu_srl;
                        end else if (w_f7 == c_f7_alt) begin
                            w_dec.alu_ctrl = c_alu_sra;
                        end else begin
                            w_dec.illegal = 1'b1;
                        end
                    end
                endcase
            end
            c_op_load: begin
                w_dec.alu_src     = 1'b1;
                w_dec.mem_read    = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.memtoreg    = 1'b1;
                w_dec.imm         = w_imm_i;
                case (w_f3)
                    3'b000:  w_dec.load_type = 3'b000;
                    3'b001:  w_dec.load_type = 3'b001;
                    3'b010:  w_dec.load_type = 3'b010;
                    3'b100:  w_dec.load_type = 3'b011;
                    3'b101:  w_dec.load_type = 3'b100;
                    default: w_dec.illegal   = 1'b1;
                endcase
            end
            c_op_store: begin
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.imm       = w_imm_s;
                if (w_f3 > 3'b010) begin
                    w_dec.illegal = 1'b1;
                end else begin
                    w_dec.store_type = w_f3[1:0];
                end
            end
            c_op_branch: begin
                w_dec.branch   = 1'b1;
                w_dec.alu_ctrl = c_alu_sub;
                w_dec.imm      = w_imm_b;
                w_dec.illegal  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            c_op_jal: begin
                w_dec.jal         = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.imm         = w_imm_j;
            end
            c_op_jalr: begin
                w_dec.jalr        = 1'b1;
                w_dec.alu_src     = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.imm         = w_imm_i;
                w_dec.illegal     = (w_f3 != 3'b000);
            end
            c_op_lui: begin
                w_dec.lui         = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.alu_ctrl    = c_alu_lui;
                w_dec.imm         = w_imm_u;
            end
            c_op_auipc: begin
                w_dec.auipc       = 1'b1;
                w_dec.wb_reg_file = 1'b1;
                w_dec.alu_ctrl    = c_alu_auipc;
                w_dec.imm         = w_imm_u;
            end
            default: w_dec.illegal = 1'b1;
        endcase
        // An illegal bundle must not have architectural side effects downstream.
        if (w_dec.illegal) begin
            w_dec.mem_write   = 1'b0;
            w_dec.mem_read    = 1'b0;
            w_dec.wb_reg_file = 1'b0;
            w_dec.branch      = 1'b0;
            w_dec.jal         = 1'b0;
            w_dec.jalr        = 1'b0;
        end
    end

    assign w_in_fire  = bus.in_valid && r_in_ready;
    assign w_out_fire = r_m_valid && bus.out_ready;

    // Skid buffer control. in_ready is recomputed as "S will be empty" so it
    // is always a plain flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_empty;
            r_m_valid  <= 1'b0;
            r_in_ready <= 1'b1;
            r_m        <= w_reset_bundle;
            r_s        <= w_reset_bundle;
        end else if (bus.flush) begin
            r_state    <= c_st_empty;
            r_m_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                c_st_empty: begin
                    if (w_in_fire) begin
                        r_m       <= w_dec;
                        r_m_valid <= 1'b1;
                        r_state   <= c_st_one;
                    end
                end
                c_st_one: begin
                    if (w_in_fire && w_out_fire) begin
                        r_m <= w_dec;
                    end else if (w_in_fire) begin
                        r_s        <= w_dec;
                        r_state    <= c_st_full;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_st_empty;
                    end
                end
                c_st_full: begin
                    if (w_out_fire) begin
                        r_m        <= r_s;
                        r_state    <= c_st_one;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_st_empty;
                    r_m_valid  <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready           = r_in_ready;
    assign bus.out_valid          = r_m_valid;
    assign bus.out_pc             = r_m.pc;
    assign bus.out_rs1            = r_m.rs1;
    assign bus.out_rs2            = r_m.rs2;
    assign bus.out_rd             = r_m.rd;
    assign bus.out_imm            = r_m.imm;
    assign bus.out_alu_src        = r_m.alu_src;
    assign bus.out_mem_write      = r_m.mem_write;
    assign bus.out_mem_read       = r_m.mem_read;
    assign bus.out_wb_reg_file    = r_m.wb_reg_file;
    assign bus.out_memtoreg       = r_m.memtoreg;
    assign bus.out_branch         = r_m.branch;
    assign bus.out_jal            = r_m.jal;
    assign bus.out_jalr           = r_m.jalr;
    assign bus.out_auipc          = r_m.auipc;
    assign bus.out_lui            = r_m.lui;
    assign bus.out_mem_load_type  = r_m.load_type;
    assign bus.out_mem_store_type = r_m.store_type;
    assign bus.out_alu_ctrl       = r_m.alu_ctrl;
    assign bus.out_is_muldiv      = r_m.is_muldiv;
    assign bus.out_illegal        = r_m.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_decode_stage
// Purpose  : Self-checking bench for id_decode_stage. Two instances share one
//            stimulus stream: EN_M=1 (full check) and EN_M=0 (illegal/wb).
//            Expected bundles are queued on every accepted instruction and
//            compared when the bundle leaves the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_decode_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [9:0]  flags;   // alu_src,mem_write,mem_read,wb,memtoreg,branch,jal,jalr,auipc,lui
        logic [4:0]  alu;
        logic [31:0] imm;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic        ill;
        logic        md;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [31:0] pc;
    } sb_t;

    localparam int NV = 20;
    localparam logic [9:0] c_ill_mask = 10'b0111011100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cur_idx = 0;
    vec_t vecs [NV];
    sb_t  sb_q [$];

    id_decode_stage_if #(.XLEN(32), .PC_W(32)) bus1 ();
    id_decode_stage_if #(.XLEN(32), .PC_W(32)) bus0 ();

    assign bus0.flush     = bus1.flush;
    assign bus0.in_valid  = bus1.in_valid;
    assign bus0.in_instr  = bus1.in_instr;
    assign bus0.in_pc     = bus1.in_pc;
    assign bus0.out_ready = bus1.out_ready;

    id_decode_stage #(.XLEN(32), .PC_W(32), .EN_M(1'b1)) u_dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    id_decode_stage #(.XLEN(32), .PC_W(32), .EN_M(1'b0)) u_dut_nom (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [9:0] dut_flags();
        return {bus1.out_alu_src, bus1.out_mem_write, bus1.out_mem_read,
                bus1.out_wb_reg_file, bus1.out_memtoreg, bus1.out_branch,
                bus1.out_jal, bus1.out_jalr, bus1.out_auipc, bus1.out_lui};
    endfunction

    task automatic check_bundle(input sb_t e);
        logic [9:0] m;
        logic       ill0;
        m    = e.v.ill ? c_ill_mask : 10'h3FF;
        ill0 = e.v.ill | e.v.md;
        chk("pc",    bus1.out_pc,  e.pc);
        chk("rd",    bus1.out_rd,  e.v.instr[11:7]);
        chk("rs1",   bus1.out_rs1, e.v.instr[19:15]);
        chk("rs2",   bus1.out_rs2, e.v.instr[24:20]);
        chk("flags", dut_flags() & m, e.v.flags & m);
        chk("illegal", bus1.out_illegal, e.v.ill);
        if (!e.v.ill) begin
            chk("alu_ctrl",   bus1.out_alu_ctrl,       e.v.alu);
            chk("imm",        bus1.out_imm,            e.v.imm);
            chk("load_type",  bus1.out_mem_load_type,  e.v.ld);
            chk("store_type", bus1.out_mem_store_type, e.v.st);
            chk("is_muldiv",  bus1.out_is_muldiv,      e.v.md);
        end
        chk("nom_illegal", bus0.out_illegal, ill0);
        chk("nom_wb", bus0.out_wb_reg_file, ill0 ? 1'b0 : e.v.flags[6]);
    endtask

    task automatic send(input int i, input logic [31:0] pc, output int waits);
        cur_idx       = i;
        bus1.in_valid = 1'b1;
        bus1.in_instr = vecs[i].instr;
        bus1.in_pc    = pc;
        waits = 0;
        @(negedge clk);
        while (!bus1.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%0b required=1", bus1.in_ready);
        end
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(nm, sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   w;
        int   stalls;
        int   acc;
        int   bad;
        int   k;
        int   cnt;
        logic held_bad;

        vecs[0]  = '{32'h00500093, 10'b1001000000, 5'b00000, 32'h00000005, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[1]  = '{32'h402081B3, 10'b0001000000, 5'b00001, 32'h00000000, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 10'b0000010000, 5'b00001, 32'hFFFFFFFC, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[3]  = '{32'h027302B3, 10'b0001000000, 5'b10000, 32'h00000000, 3'b010, 2'b10, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000B083, 10'b0000000000, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b1, 1'b0};
        vecs[5]  = '{32'h0040A103, 10'b1011100000, 5'b00000, 32'h00000004, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[6]  = '{32'hFFF14183, 10'b1011100000, 5'b00000, 32'hFFFFFFFF, 3'b011, 2'b10, 1'b0, 1'b0};
        vecs[7]  = '{32'hFE512C23, 10'b1100000000, 5'b00000, 32'hFFFFFFF8, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[8]  = '{32'h00100023, 10'b1100000000, 5'b00000, 32'h00000000, 3'b010, 2'b00, 1'b0, 1'b0};
        vecs[9]  = '{32'h123452B7, 10'b0001000001, 5'b01010, 32'h12345000, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[10] = '{32'hFFFFF097, 10'b0001000010, 5'b01011, 32'hFFFFF000, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[11] = '{32'h008000EF, 10'b0001001000, 5'b00000, 32'h00000008, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[12] = '{32'h00008067, 10'b1001000100, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[13] = '{32'h4030D113, 10'b1001000000, 5'b00111, 32'h00000403, 3'b010, 2'b10, 1'b0, 1'b0};
        vecs[14] = '{32'h40309113, 10'b0000000000, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b1, 1'b0};
        vecs[15] = '{32'h00000000, 10'b0000000000, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b1, 1'b0};
        vecs[16] = '{32'h0220D1B3, 10'b0001000000, 5'b10101, 32'h00000000, 3'b010, 2'b10, 1'b0, 1'b1};
        vecs[17] = '{32'h00002063, 10'b0000000000, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b1, 1'b0};
        vecs[18] = '{32'h00009067, 10'b0000000000, 5'b00000, 32'h00000000, 3'b010, 2'b10, 1'b1, 1'b0};
        vecs[19] = '{32'h0020C1B3, 10'b0001000000, 5'b00100, 32'h00000000, 3'b010, 2'b10, 1'b0, 1'b0};

        rst            = 1'b1;
        bus1.flush     = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_instr  = 32'h0;
        bus1.in_pc     = 32'h0;
        bus1.out_ready = 1'b1;

        // Scoreboard: queue on accept, compare on bundle handoff.
        fork
            forever begin
                @(negedge clk);
                if (rst || bus1.flush) begin
                    sb_q.delete();
                end else begin
                    if (bus1.out_valid && bus1.out_ready) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output pc=%0h required=none", bus1.out_pc);
                        end else begin
                            check_bundle(sb_q.pop_front());
                        end
                    end
                    if (bus1.in_valid && bus1.in_ready)
                        sb_q.push_back('{vecs[cur_idx], bus1.in_pc});
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid",  bus1.out_valid, 0);
        chk("rst_in_ready",   bus1.in_ready, 1);
        chk("rst_load_type",  bus1.out_mem_load_type, 3'b010);
        chk("rst_store_type", bus1.out_mem_store_type, 2'b10);
        chk("rst_fields", {bus1.out_pc, bus1.out_rs1, bus1.out_rs2, bus1.out_rd}, 0);
        chk("rst_imm",        bus1.out_imm, 0);
        chk("rst_alu_ctrl",   bus1.out_alu_ctrl, 0);
        chk("rst_flags",      dut_flags(), 0);
        chk("rst_ill_md", {bus1.out_illegal, bus1.out_is_muldiv}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One-cycle latency
        send(0, 32'h00001000, w);
        @(negedge clk);
        chk("latency_out_valid", bus1.out_valid, 1);
        @(posedge clk);
        #1;

        // Full table, back-to-back with out_ready=1
        stalls = 0;
        for (int i = 0; i < NV; i++) begin
            send(i, 32'h00001000 + 32'(i * 4), w);
            stalls += w;
        end
        chk("stream_no_stall", stalls, 0);
        drain("stream_drain");

        // Backpressure: four offered, two accepted, outputs held
        bus1.out_ready = 1'b0;
        acc = 0;
        bad = 0;
        k = 0;
        held_bad = 1'b0;
        cur_idx = 0;
        bus1.in_valid = 1'b1;
        bus1.in_instr = vecs[0].instr;
        bus1.in_pc    = 32'h00002000;
        repeat (6) begin
            @(negedge clk);
            if (acc >= 2 && bus1.in_ready) bad++;
            if (acc >= 1 && bus1.out_pc !== 32'h00002000) held_bad = 1'b1;
            if (bus1.in_ready) acc++;
            @(posedge clk);
            #1;
            if (acc > k && k < 3) begin
                k++;
                cur_idx = k;
                bus1.in_instr = vecs[k].instr;
                bus1.in_pc    = 32'h00002000 + 32'(k * 4);
            end
        end
        chk("bp_accepted",    acc, 2);
        chk("bp_ready_low",   bad, 0);
        chk("bp_in_ready",    bus1.in_ready, 0);
        chk("bp_out_held",    held_bad, 0);
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b1;
        drain("bp_drain");
        @(negedge clk);
        chk("bp_in_ready_back", bus1.in_ready, 1);
        @(posedge clk);
        #1;

        // Flush while FULL with a third instruction offered
        bus1.out_ready = 1'b0;
        send(5, 32'h00003000, w);
        send(6, 32'h00003004, w);
        cur_idx = 7;
        bus1.in_valid = 1'b1;
        bus1.in_instr = vecs[7].instr;
        bus1.in_pc    = 32'h00003008;
        bus1.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus1.flush    = 1'b0;
        bus1.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", bus1.out_valid, 0);
        chk("flush_in_ready",  bus1.in_ready, 1);
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus1.out_valid) cnt++;
        end
        chk("flush_no_emit", cnt, 0);
        @(posedge clk);
        #1;

        // Reset while occupied
        bus1.out_ready = 1'b0;
        send(9, 32'h00004000, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bus1.out_valid, 0);
        chk("midrst_in_ready",  bus1.in_ready, 1);
        chk("midrst_load_type", bus1.out_mem_load_type, 3'b010);

        // Traffic after flush/reset still decodes correctly
        @(posedge clk);
        #1;
        bus1.out_ready = 1'b1;
        send(16, 32'h00005000, w);
        send(13, 32'h00005004, w);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
